// File: rtl/motion_mask_stream.sv
// rtl/motion_mask_stream.sv - per-lane |y-x| > threshold mask stream with per-frame motion statistics
module motion_mask_stream #(
   parameter int PIX_WIDTH   = 8,
   parameter int LANES       = 4,
   parameter int FRAME_WORDS = 76800,
   parameter int THRESHOLD   = 50,
   parameter int MIN_PIXELS  = 64,
   parameter int CNT_WIDTH   = $clog2(FRAME_WORDS*LANES+1)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [PIX_WIDTH-1:0]         threshold,
   input  logic [PIX_WIDTH*LANES-1:0]   x_dout,
   input  logic                         x_empty,
   output logic                         x_rd_en,
   input  logic [PIX_WIDTH*LANES-1:0]   y_dout,
   input  logic                         y_empty,
   output logic                         y_rd_en,
   output logic [PIX_WIDTH*LANES-1:0]   z_din,
   input  logic                         z_full,
   output logic                         z_wr_en,
   output logic                         frame_done,
   output logic [CNT_WIDTH-1:0]         motion_count,
   output logic                         motion_detected
);
   localparam int DATA_WIDTH = PIX_WIDTH*LANES;
   localparam int WC_WIDTH   = $clog2(FRAME_WORDS);
   localparam logic [WC_WIDTH-1:0]  LAST_WORD = WC_WIDTH'(FRAME_WORDS-1);
   localparam logic [CNT_WIDTH-1:0] MIN_COUNT = CNT_WIDTH'(MIN_PIXELS);
   localparam logic [PIX_WIDTH-1:0] THR_RESET = PIX_WIDTH'(THRESHOLD);

   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_q;
   logic [WC_WIDTH-1:0]   word_cnt;
   logic [CNT_WIDTH-1:0]  accumulator;
   logic [PIX_WIDTH-1:0]  thr_q;

   logic                  pop;
   logic                  first_word;
   logic                  last_word;
   logic [PIX_WIDTH-1:0]  thr_use;
   logic [LANES-1:0]      hit;
   logic [DATA_WIDTH-1:0] mask;
   logic [CNT_WIDTH-1:0]  pc;
   logic [CNT_WIDTH-1:0]  acc_next;

   // Pop is allowed while the output slot drains in the same cycle, giving full rate.
   assign pop        = !x_empty && !y_empty && (!out_valid || !z_full);
   assign x_rd_en    = pop;
   assign y_rd_en    = pop;
   assign z_wr_en    = out_valid && !z_full;
   assign z_din      = out_valid ? out_q : '0;

   assign first_word = (word_cnt == '0);
   assign last_word  = (word_cnt == LAST_WORD);
   assign thr_use    = first_word ? threshold : thr_q;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [PIX_WIDTH-1:0] px;
      logic [PIX_WIDTH-1:0] py;
      logic [PIX_WIDTH-1:0] diff;
      assign px   = x_dout[i*PIX_WIDTH +: PIX_WIDTH];
      assign py   = y_dout[i*PIX_WIDTH +: PIX_WIDTH];
      assign diff = (py >= px) ? (py - px) : (px - py);
      assign hit[i] = (diff > thr_use);
      assign mask[i*PIX_WIDTH +: PIX_WIDTH] = {PIX_WIDTH{hit[i]}};
   end

   always_comb begin
      pc = '0;
      for (int i = 0; i < LANES; i++) begin
         pc = pc + CNT_WIDTH'(hit[i]);
      end
      acc_next = (first_word ? '0 : accumulator) + pc;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid       <= 1'b0;
         out_q           <= '0;
         word_cnt        <= '0;
         accumulator     <= '0;
         thr_q           <= THR_RESET;
         frame_done      <= 1'b0;
         motion_count    <= '0;
         motion_detected <= 1'b0;
      end else begin
         frame_done <= pop && last_word;
         if (pop) begin
            out_q       <= mask;
            out_valid   <= 1'b1;
            word_cnt    <= last_word ? '0 : word_cnt + 1'b1;
            accumulator <= acc_next;
            if (first_word) begin
               thr_q <= threshold;
            end
            if (last_word) begin
               motion_count    <= acc_next;
               motion_detected <= (acc_next >= MIN_COUNT);
            end
         end else if (z_wr_en) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_motion_mask_stream.sv
// tb/tb_motion_mask_stream.sv - directed and randomised self-checking bench for motion_mask_stream
module tb_motion_mask_stream;
   localparam int FW = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  threshold = 8'd50;
   logic [31:0] x_dout = '0;
   logic        x_empty = 1'b1;
   logic        x_rd_en;
   logic [31:0] y_dout = '0;
   logic        y_empty = 1'b1;
   logic        y_rd_en;
   logic [31:0] z_din;
   logic        z_full = 1'b0;
   logic        z_wr_en;
   logic        frame_done;
   logic [4:0]  motion_count;
   logic        motion_detected;

   motion_mask_stream #(
      .PIX_WIDTH(8), .LANES(4), .FRAME_WORDS(FW), .THRESHOLD(50), .MIN_PIXELS(5)
   ) dut (
      .clock(clock), .reset(reset), .threshold(threshold),
      .x_dout(x_dout), .x_empty(x_empty), .x_rd_en(x_rd_en),
      .y_dout(y_dout), .y_empty(y_empty), .y_rd_en(y_rd_en),
      .z_din(z_din), .z_full(z_full), .z_wr_en(z_wr_en),
      .frame_done(frame_done), .motion_count(motion_count),
      .motion_detected(motion_detected)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   logic [31:0] xq[$];
   logic [31:0] yq[$];
   logic [7:0]  tq[$];
   logic [31:0] zq[$];
   int          fd_cnt[$];
   int          fd_det[$];
   bit          mv = 0;
   bit          fd_exp = 0;
   int          wc = 0;
   bit          rnd = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mask_of(input logic [31:0] x, input logic [31:0] y, input int thr);
      logic [31:0] m;
      int d;
      m = '0;
      for (int i = 0; i < 4; i++) begin
         d = int'(y[i*8 +: 8]) - int'(x[i*8 +: 8]);
         if (d < 0) d = -d;
         if (d > thr) m[i*8 +: 8] = 8'hFF;
      end
      return m;
   endfunction

   task automatic add(input logic [31:0] x, input logic [31:0] y, input logic [7:0] t, input logic [31:0] z);
      xq.push_back(x); yq.push_back(y); tq.push_back(t); zq.push_back(z);
   endtask

   task automatic step();
      bit exp_pop, exp_push;
      @(negedge clock);
      x_empty = (xq.size() == 0) || (rnd && $urandom_range(0, 7) == 0);
      y_empty = (yq.size() == 0) || (rnd && $urandom_range(0, 7) == 0);
      x_dout  = (xq.size() != 0) ? xq[0] : 32'h0;
      y_dout  = (yq.size() != 0) ? yq[0] : 32'h0;
      if (tq.size() != 0) threshold = tq[0];
      z_full  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      exp_pop  = !x_empty && !y_empty && (!mv || !z_full);
      exp_push = mv && !z_full;
      check("x_rd_en", x_rd_en, exp_pop);
      check("y_rd_en", y_rd_en, exp_pop);
      check("z_wr_en", z_wr_en, exp_push);
      check("frame_done", frame_done, fd_exp);
      if (frame_done) begin
         fd_cnt.push_back(int'(motion_count));
         fd_det.push_back(int'(motion_detected));
      end
      if (exp_push) begin
         if (zq.size() == 0) check("z_unexpected_push", 1, 0);
         else check("z_din", z_din, zq.pop_front());
      end else if (!mv) begin
         check("z_din_idle", z_din, 0);
      end
      @(posedge clock);
      if (exp_pop) begin
         void'(xq.pop_front()); void'(yq.pop_front());
         if (tq.size() != 0) void'(tq.pop_front());
         mv = 1;
         fd_exp = (wc == FW-1);
         wc = (wc + 1) % FW;
      end else begin
         if (exp_push) mv = 0;
         fd_exp = 0;
      end
   endtask

   task automatic run(input int budget);
      int n = 0;
      while ((xq.size() != 0 || zq.size() != 0 || mv) && n < budget) begin
         step();
         n++;
      end
      check("drain_within_budget", n < budget, 1);
   endtask

   task automatic do_reset();
      @(negedge clock);
      #2;
      reset = 1'b1;
      xq.delete(); yq.delete(); tq.delete(); zq.delete();
      fd_cnt.delete(); fd_det.delete();
      mv = 0; fd_exp = 0; wc = 0;
      x_empty = 1'b1; y_empty = 1'b1; z_full = 1'b0;
      #1;
      check("rst_x_rd_en", x_rd_en, 0);
      check("rst_z_wr_en", z_wr_en, 0);
      check("rst_z_din", z_din, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_motion_count", motion_count, 0);
      check("rst_motion_detected", motion_detected, 0);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] rx, ry;
      do_reset();

      // Single word at default threshold, and the abs-difference case
      add(32'h0000_0000, 32'h3332_00FF, 8'd50, 32'hFF00_00FF);
      run(50);
      do_reset();
      add(32'hFF10_8000, 32'h0090_7F40, 8'd63, 32'hFFFF_00FF);
      run(50);

      // Threshold extremes: 0 flags any difference, 255 never flags
      do_reset();
      add(32'h1010_1010, 32'h1010_1110, 8'd0,   32'h0000_FF00);
      add(32'h0000_0000, 32'h0100_0000, 8'd255, 32'hFF00_0000);
      run(50);
      do_reset();
      add(32'h00FF_00FF, 32'hFF00_FF00, 8'd255, 32'h0000_0000);
      run(50);

      // Two back-to-back frames: 1,2,0,1 motion lanes then all lanes
      do_reset();
      add(32'h0, 32'h0000_00FF, 8'd50, 32'h0000_00FF);
      add(32'h0, 32'h0000_FFFF, 8'd50, 32'h0000_FFFF);
      add(32'h0, 32'h0000_0000, 8'd50, 32'h0000_0000);
      add(32'h0, 32'hFF00_0000, 8'd50, 32'hFF00_0000);
      for (int i = 0; i < 4; i++) add(32'h0, 32'hFFFF_FFFF, 8'd50, 32'hFFFF_FFFF);
      run(100);
      check("frames_seen", fd_cnt.size(), 2);
      if (fd_cnt.size() == 2) begin
         check("f1_count", fd_cnt[0], 4);
         check("f1_detect", fd_det[0], 0);
         check("f2_count", fd_cnt[1], 16);
         check("f2_detect", fd_det[1], 1);
      end
      check("count_holds", motion_count, 16);

      // Threshold port change mid-frame only takes effect at the next frame
      do_reset();
      add(32'h0, 32'h1E1E_1E1E, 8'd50, 32'h0);
      add(32'h0, 32'h1E1E_1E1E, 8'd50, 32'h0);
      add(32'h0, 32'h1E1E_1E1E, 8'd10, 32'h0);
      add(32'h0, 32'h1E1E_1E1E, 8'd10, 32'h0);
      add(32'h0, 32'h1E1E_1E1E, 8'd10, 32'hFFFF_FFFF);
      for (int i = 0; i < 3; i++) add(32'h0, 32'h1E1E_1E1E, 8'd50, 32'hFFFF_FFFF);
      run(100);
      check("thr_frames_seen", fd_cnt.size(), 2);
      if (fd_cnt.size() == 2) begin
         check("thr_f1_count", fd_cnt[0], 0);
         check("thr_f2_count", fd_cnt[1], 16);
      end

      // Reset after two words of a frame: partial frame is discarded
      add(32'h0, 32'hFFFF_FFFF, 8'd50, 32'hFFFF_FFFF);
      add(32'h0, 32'hFFFF_FFFF, 8'd50, 32'hFFFF_FFFF);
      step();
      step();
      do_reset();
      for (int i = 0; i < 3; i++) add(32'h0, 32'h0000_00FF, 8'd50, 32'h0000_00FF);
      add(32'h0, 32'h0, 8'd50, 32'h0);
      run(50);
      check("after_rst_frames", fd_cnt.size(), 1);
      if (fd_cnt.size() == 1) begin
         check("after_rst_count", fd_cnt[0], 3);
         check("after_rst_detect", fd_det[0], 0);
      end

      // Random stream with back-pressure and input gaps, then a full-rate burst
      do_reset();
      rnd = 1;
      for (int i = 0; i < 100; i++) begin
         rx = $urandom; ry = $urandom;
         add(rx, ry, 8'd40, mask_of(rx, ry, 40));
      end
      run(2000);
      rnd = 0;
      for (int i = 0; i < 20; i++) begin
         rx = $urandom; ry = $urandom;
         add(rx, ry, 8'd40, mask_of(rx, ry, 40));
      end
      run(100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
